param_regfile: RTL and testbench
================================

# param_regfile

Parametrised multi-read-port register file with a sequential power-on initialiser; the next-generation replacement for the fixed 4-entry scratch memory used in the array examples. It provides one write port, NUM_RD independent registered read ports, and an index-pattern initialisation sequence that runs one entry per cycle after every reset. It sits between a control FSM and datapath consumers as a small lookup or scratch store.

## Interface
- DATA_W, 8, entry width in bits (≥1)
- DEPTH, 16, number of entries (≥2; need not be a power of two)
- ADDR_W, 4, address width; must satisfy 2^ADDR_W ≥ DEPTH
- NUM_RD, 2, number of read ports (1..4)

- i_sys_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_wr  in  1  write strobe
- i_wr_addr  in  ADDR_W  write address
- i_wr_data  in  DATA_W  write data
- i_rd  in  NUM_RD  per-port read strobe
- i_rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- o_rd_data  out  NUM_RD*DATA_W  packed registered read data; port p at [p*DATA_W +: DATA_W]
- o_rd_vld  out  NUM_RD  per-port read-valid pulse
- o_init_done  out  1  high once initialisation is complete

## Operation
- States: INIT, READY. Any edge with i_rst_n=0 forces INIT, init counter=0, o_rd_data=0, o_rd_vld=0, o_init_done=0. Array contents are not reset in one cycle.
- INIT: each edge with i_rst_n=1 writes mem[cnt] = cnt mod 2^DATA_W (zero-extended if DATA_W > ADDR_W), then cnt++. The edge writing DEPTH-1 moves to READY and sets o_init_done=1.
- In INIT, i_wr and i_rd are ignored; o_rd_vld stays 0.
- READY, write: i_wr=1 with i_wr_addr < DEPTH writes i_wr_data on that edge. i_wr_addr ≥ DEPTH: write dropped silently.
- READY, read port p: i_rd[p]=1 captures mem[addr_p] into o_rd_data[p] and sets o_rd_vld[p]=1 for one cycle. addr_p ≥ DEPTH returns 0, o_rd_vld still pulses.
- i_rd[p]=0: o_rd_data[p] holds its previous value; o_rd_vld[p]=0.
- Multiple ports reading the same address in the same cycle each return identical data.
- Read and write to the same address in the same cycle: see Configuration.
- Reset mid-INIT or mid-READY restarts INIT from entry 0; user writes made before that reset are overwritten.

## Timing
- Read latency 1: strobe at edge k, data and vld valid after edge k.
- o_init_done rises after the DEPTH-th consecutive rising edge with i_rst_n=1. Reads or writes presented in that same cycle are accepted on the next edge.
- A write at edge k is visible to a read issued at edge k+1 in both configurations.
- Full throughput: one write plus NUM_RD reads every cycle in READY; no stalls.

## Configuration
- PARAM_REGFILE_BYPASS_EN defined: same-cycle read and write to the same in-range address returns the new i_wr_data (write-first).
- PARAM_REGFILE_BYPASS_EN undefined: the read returns the old stored value (read-first).
- The write always lands in both cases.

## Structure
- Package param_regfile_pkg:
  - state enum (ST_INIT, ST_READY)
  - default parameter constants
  - a function computing the init pattern from an index
- Sub-module regfile_init_seq:
  - owns the INIT/READY FSM and the init counter
  - outputs init write enable, address, data and done
  - the top muxes the init write path against the user write path

## Test plan
- Init pattern (DATA_W=8, DEPTH=16): release reset, hold i_rd=0 → o_init_done rises after exactly 16 edges; then read all 16 addresses on port 0 → data 0x00..0x0F in order, each with vld=1 one cycle after its strobe.
- Write/read: write 0xA5 to addr 3; next cycle read addr 3 on ports 0 and 1 simultaneously → both return 0xA5, vld=2'b11.
- Collision: mem[5]=0x05, same cycle write 0x5A to addr 5 and read addr 5 → 0x5A with BYPASS_EN defined, 0x05 without; a read of addr 5 in the following cycle returns 0x5A in both builds.
- Out of range (DEPTH=12, ADDR_W=4): write 0xFF to addr 13, read addr 13 → data 0x00, vld=1; a full readback shows entries 0..11 unchanged.
- Reset mid-operation: write 0x77 to addr 2; assert i_rst_n=0 for one edge during a pending read → o_rd_vld=0, o_rd_data=0, o_init_done=0; after re-init, addr 2 reads 0x02.
- Ignored during INIT: pulse i_wr (addr 0, 0xEE) and i_rd in the cycle after reset release → no vld pulse; after init, addr 0 reads 0x00.

Source files
------------

// File: rtl/param_regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Build option: PARAM_REGFILE_BYPASS_EN selects write-first reads.
package param_regfile_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;

  // Callers resize the result to DATA_W (truncate or zero-extend).
  function automatic logic [31:0] init_pat(
    input logic [31:0] idx
  );
    return idx;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// INIT/READY sequencer for param_regfile.
// Writes the index pattern one entry per cycle after each reset.
module regfile_init_seq
  import param_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = i_rst_n;
        if (cnt_q == LAST)
          state_d = ST_READY;
        else
          cnt_d = cnt_q + ADDR_W'(1);
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  assign init_addr = cnt_q;
  assign init_data = DATA_W'(init_pat(32'(cnt_q)));
  assign init_done = (state_q == ST_READY);

endmodule

// File: rtl/param_regfile.sv
// Multi-read-port register file with power-on index initialiser.
// Build option: PARAM_REGFILE_BYPASS_EN selects write-first reads.
module param_regfile
  import param_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [NUM_RD-1:0]        i_rd,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_vld,
  output logic                     o_init_done
);

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W + 1)'(DEPTH);

`ifdef PARAM_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              ready;
  logic              wr_ok;

  regfile_init_seq #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_done (ready)
  );

  assign wr_ok = i_rst_n && ready && i_wr &&
                 ({1'b0, i_wr_addr} < DEPTH_L);

  // Init path owns the array until READY.
  always_ff @(posedge i_sys_clk) begin
    if (init_we)
      mem[init_addr] <= init_data;
    else if (wr_ok)
      mem[i_wr_addr] <= i_wr_data;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              in_rng;
    logic              hit;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] data_q;
    logic              vld_q;

    assign addr   = i_rd_addr[p*ADDR_W +: ADDR_W];
    assign in_rng = ({1'b0, addr} < DEPTH_L);
    assign hit    = BYPASS && wr_ok &&
                    (i_wr_addr == addr);
    assign rd_val = !in_rng ? '0 :
                    hit     ? i_wr_data :
                              mem[addr];

    always_ff @(posedge i_sys_clk) begin
      if (!i_rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= ready & i_rd[p];
        if (ready && i_rd[p])
          data_q <= rd_val;
      end
    end

    assign o_rd_data[p*DATA_W +: DATA_W] = data_q;
    assign o_rd_vld[p]                   = vld_q;
  end

  assign o_init_done = ready;

endmodule

// File: tb/tb_param_regfile.sv
// Randomised self-checking bench for param_regfile.
// Drives a DEPTH=16 and a DEPTH=12 instance with shared stimulus.
module tb_param_regfile;

`ifdef PARAM_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr    = 1'b0;
  logic [3:0] wa    = '0;
  logic [7:0] wd    = '0;
  logic [1:0] rd    = '0;
  logic [7:0] ra    = '0;

  logic [15:0] d16_data, d12_data;
  logic [1:0]  d16_vld, d12_vld;
  logic        d16_done, d12_done;

  logic [15:0] od [2];
  logic [1:0]  ov [2];
  logic        odn [2];

  assign od[0]  = d16_data;
  assign od[1]  = d12_data;
  assign ov[0]  = d16_vld;
  assign ov[1]  = d12_vld;
  assign odn[0] = d16_done;
  assign odn[1] = d12_done;

  int checks = 0;
  int errors = 0;

  int unsigned mm [2][16];
  int dep [2] = '{16, 12};
  int edges [2];
  int ev [2];
  int ed [2][2];

  always #5 clk = ~clk;

  param_regfile #(
    .DATA_W(8), .DEPTH(16), .ADDR_W(4), .NUM_RD(2)
  ) u_d16 (
    .i_sys_clk   (clk),
    .i_rst_n     (rst_n),
    .i_wr        (wr),
    .i_wr_addr   (wa),
    .i_wr_data   (wd),
    .i_rd        (rd),
    .i_rd_addr   (ra),
    .o_rd_data   (d16_data),
    .o_rd_vld    (d16_vld),
    .o_init_done (d16_done)
  );

  param_regfile #(
    .DATA_W(8), .DEPTH(12), .ADDR_W(4), .NUM_RD(2)
  ) u_d12 (
    .i_sys_clk   (clk),
    .i_rst_n     (rst_n),
    .i_wr        (wr),
    .i_wr_addr   (wa),
    .i_wr_data   (wd),
    .i_rd        (rd),
    .i_rd_addr   (ra),
    .o_rd_data   (d12_data),
    .o_rd_vld    (d12_vld),
    .o_init_done (d12_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference: ready once DEPTH good edges have elapsed.
  task automatic model_step(input int k,
                            input bit r, input bit w,
                            input int a, input int d,
                            input int rdv,
                            input int a0, input int a1);
    int pa [2];
    int ad;
    pa[0] = a0;
    pa[1] = a1;
    if (!r) begin
      edges[k] = 0;
      ev[k]    = 0;
      ed[k][0] = 0;
      ed[k][1] = 0;
    end else if (edges[k] < dep[k]) begin
      edges[k]++;
      ev[k] = 0;
      if (edges[k] == dep[k])
        for (int i = 0; i < dep[k]; i++)
          mm[k][i] = i % 256;
    end else begin
      ev[k] = rdv;
      for (int p = 0; p < 2; p++) begin
        if (((rdv >> p) & 1) != 0) begin
          ad = pa[p];
          if (ad >= dep[k])
            ed[k][p] = 0;
          else if (BYP && w && a == ad)
            ed[k][p] = d;
          else
            ed[k][p] = mm[k][ad];
        end
      end
      if (w && a < dep[k])
        mm[k][a] = d;
    end
  endtask

  task automatic cyc(input bit r, input bit w,
                     input int a, input int d,
                     input int rdv,
                     input int a0, input int a1);
    @(negedge clk);
    rst_n = r;
    wr    = w;
    wa    = 4'(a);
    wd    = 8'(d);
    rd    = 2'(rdv);
    ra    = {4'(a1), 4'(a0)};
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      model_step(k, r, w, a, d, rdv, a0, a1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done_d%0d", dep[k]),
          32'(odn[k]),
          32'(edges[k] >= dep[k]));
      chk($sformatf("vld_d%0d", dep[k]),
          32'(ov[k]), 32'(ev[k]));
      for (int p = 0; p < 2; p++)
        chk($sformatf("data_d%0d_p%0d", dep[k], p),
            32'(od[k][p*8 +: 8]),
            32'(ed[k][p]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int a, a0;

    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 3, 1, 2);
    cyc(1, 1, 0, 'hEE, 3, 0, 0);
    idle(15);

    for (int i = 0; i < 16; i++)
      cyc(1, 0, 0, 0, 1, i, 15 - i);
    cyc(1, 0, 0, 0, 3, 0, 0);

    cyc(1, 1, 3, 'hA5, 0, 0, 0);
    cyc(1, 0, 0, 0, 3, 3, 3);

    cyc(1, 1, 5, 'h5A, 3, 5, 5);
    cyc(1, 0, 0, 0, 3, 5, 5);

    cyc(1, 1, 13, 'hFF, 0, 0, 0);
    cyc(1, 0, 0, 0, 3, 13, 13);
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 0, 0, 3, i, i);

    cyc(1, 1, 2, 'h77, 0, 0, 0);
    cyc(0, 0, 0, 0, 3, 2, 2);
    idle(16);
    cyc(1, 0, 0, 0, 3, 2, 11);

    for (int i = 0; i < 600; i++) begin
      a  = $urandom_range(0, 15);
      a0 = ($urandom_range(0, 3) == 0) ?
           a : $urandom_range(0, 15);
      cyc($urandom_range(0, 79) != 0,
          1'($urandom_range(0, 1)),
          a,
          $urandom_range(0, 255),
          $urandom_range(0, 3),
          a0,
          $urandom_range(0, 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
